// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if: writeback request bundle for ports A and B.
// master = requesters (pipeline wb / multi-cycle unit), slave = arbiter.
interface regfile_wb_arbiter_if;
    logic        a_valid;
    logic        a_ready;
    logic [4:0]  a_waddr;
    logic [31:0] a_wdata;
    logic        b_valid;
    logic        b_ready;
    logic [4:0]  b_waddr;
    logic [31:0] b_wdata;

    modport master (
        output a_valid, a_waddr, a_wdata,
        output b_valid, b_waddr, b_wdata,
        input  a_ready, b_ready
    );

    modport slave (
        input  a_valid, a_waddr, a_wdata,
        input  b_valid, b_waddr, b_wdata,
        output a_ready, b_ready
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: merges pipeline (A) and multi-cycle (B) writebacks
// onto the single regfile write port; B is queued when it cannot issue.
// Optional read-after-write hazard ports: define REGWB_HAZARD_EN.
module regfile_wb_arbiter #(
    parameter int DEPTH        = 4,
    parameter int AW           = 2,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    regfile_wb_arbiter_if.slave    wb,
    output logic                   we,
    output logic [4:0]             waddr,
    output logic [31:0]            wdata,
`ifdef REGWB_HAZARD_EN
    output logic [AW:0]            fifo_count,
    input  logic [4:0]             raddr1,
    input  logic [4:0]             raddr2,
    output logic                   hazard1,
    output logic                   hazard2
`else
    output logic [AW:0]            fifo_count
`endif
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);
    localparam logic [SW-1:0] SLIM = SW'(STARVE_LIMIT);

    logic [4:0]    q_addr [DEPTH];
    logic [31:0]   q_data [DEPTH];
    logic [AW-1:0] rptr;
    logic [AW-1:0] wptr;
    logic [SW-1:0] starve;

    logic a_fire, b_fire, a_iss, b_nz, pop, byp, push, empty;

    assign empty      = (fifo_count == '0);
    assign wb.a_ready = !rst && !(starve == SLIM && !empty);
    assign wb.b_ready = !rst && (fifo_count != FULL);

    assign a_fire = wb.a_valid && wb.a_ready;
    assign b_fire = wb.b_valid && wb.b_ready;
    assign a_iss  = a_fire && (wb.a_waddr != 5'd0);
    assign b_nz   = b_fire && (wb.b_waddr != 5'd0);
    assign pop    = !a_iss && !empty;
    assign byp    = !a_iss && empty && b_nz;
    assign push   = b_nz && !byp;

    // Select one write per cycle and register it onto the regfile port.
    always_ff @(posedge clk) begin
        if (rst) begin
            we    <= 1'b0;
            waddr <= 5'd0;
            wdata <= 32'd0;
        end else begin
            we <= a_iss || pop || byp;
            unique case (1'b1)
                a_iss: begin
                    waddr <= wb.a_waddr;
                    wdata <= wb.a_wdata;
                end
                pop: begin
                    waddr <= q_addr[rptr];
                    wdata <= q_data[rptr];
                end
                byp: begin
                    waddr <= wb.b_waddr;
                    wdata <= wb.b_wdata;
                end
                default: ;
            endcase
        end
    end

    // FIFO storage; contents need no reset since count gates validity.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            q_addr[wptr] <= wb.b_waddr;
            q_data[wptr] <= wb.b_wdata;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            rptr       <= '0;
            wptr       <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            unique case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: ;
            endcase
        end
    end

    // Count A wins over a waiting queue so B cannot starve.
    always_ff @(posedge clk) begin
        if (rst || pop || empty) begin
            starve <= '0;
        end else if (a_iss && starve != SLIM) begin
            starve <= starve + 1'b1;
        end
    end

`ifdef REGWB_HAZARD_EN
    function automatic logic pending(input logic [4:0] ra);
        logic hit;
        hit = (ra != 5'd0) && we && (waddr == ra);
        for (int i = 0; i < DEPTH; i++) begin
            if ((AW + 1)'(i) < fifo_count &&
                q_addr[rptr + AW'(i)] == ra && ra != 5'd0) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    assign hazard1 = pending(raddr1);
    assign hazard2 = pending(raddr2);
`endif

endmodule
